// File: rtl/hit_resolver.sv
// Hit resolver: turns hit-detector flags into health loss, hitstun, post-hit
// invulnerability and the end-of-round result for a two-player fighting game.
module hit_resolver #(
  parameter logic [6:0] MAX_HEALTH    = 7'd100,
  parameter logic [6:0] BASIC_DMG     = 7'd10,
  parameter logic [6:0] DIR_DMG       = 7'd15,
  parameter logic [5:0] STUN_FRAMES   = 6'd20,
  parameter logic [5:0] INVULN_FRAMES = 6'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       round_start,
  input  logic       hitscan1,
  input  logic       hitscan2,
  input  logic [3:0] Player1NS,
  input  logic [3:0] Player2NS,
  output logic [6:0] health1,
  output logic [6:0] health2,
  output logic       stun1,
  output logic       stun2,
  output logic       invuln1,
  output logic       invuln2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {DEF_IDLE, DEF_STUN, DEF_INVULN} def_state_e;
  typedef enum logic {ROUND_PLAYING, ROUND_OVER} round_state_e;

  // A zero-length phase still lasts exactly one frame_tick.
  localparam logic [5:0] STUN_LOAD   = (STUN_FRAMES == 6'd0)   ? 6'd0 : STUN_FRAMES - 6'd1;
  localparam logic [5:0] INVULN_LOAD = (INVULN_FRAMES == 6'd0) ? 6'd0 : INVULN_FRAMES - 6'd1;

  round_state_e round_state_q, round_state_d;
  logic [1:0]   winner_q, winner_d;
  logic         game_over_q, game_over_d;
  logic         health1_zero, health2_zero;
  logic         force_idle;

  logic [1:0] hitscan_v;
  logic [3:0] attacker_ns [2];

  assign hitscan_v      = {hitscan2, hitscan1};
  assign attacker_ns[0] = Player2NS;
  assign attacker_ns[1] = Player1NS;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_def
      def_state_e state_q, state_d;
      logic [5:0] cnt_q, cnt_d;
      logic [6:0] health_q, health_d;
      logic       hit_prev_q;
      logic       stun_q, stun_d;
      logic       invuln_q, invuln_d;
      logic       hev;
      logic [6:0] dmg;
      logic       dmg_valid;

      assign hev = hitscan_v[gi] & ~hit_prev_q;

      always_comb begin
        dmg       = 7'd0;
        dmg_valid = 1'b0;
        case (attacker_ns[gi])
          4'd4: begin dmg = BASIC_DMG; dmg_valid = 1'b1; end
          4'd7: begin dmg = DIR_DMG;   dmg_valid = 1'b1; end
          default: ;
        endcase
      end

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        health_d = health_q;
        if (round_start) begin
          state_d  = DEF_IDLE;
          cnt_d    = 6'd0;
          health_d = MAX_HEALTH;
        end else if (force_idle) begin
          // Round is over (or ending this edge): health frozen, no stun/invuln.
          state_d = DEF_IDLE;
          cnt_d   = 6'd0;
        end else begin
          case (state_q)
            DEF_IDLE: begin
              if (hev && dmg_valid) begin
                health_d = (health_q > dmg) ? health_q - dmg : 7'd0;
                state_d  = DEF_STUN;
                cnt_d    = STUN_LOAD;
              end
            end
            DEF_STUN: begin
              if (frame_tick) begin
                if (cnt_q == 6'd0) begin
                  state_d = DEF_INVULN;
                  cnt_d   = INVULN_LOAD;
                end else begin
                  cnt_d = cnt_q - 6'd1;
                end
              end
            end
            DEF_INVULN: begin
              if (frame_tick) begin
                if (cnt_q == 6'd0) state_d = DEF_IDLE;
                else               cnt_d   = cnt_q - 6'd1;
              end
            end
            default: begin
              state_d = DEF_IDLE;
              cnt_d   = 6'd0;
            end
          endcase
        end
        stun_d   = (state_d == DEF_STUN);
        invuln_d = (state_d == DEF_INVULN);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= DEF_IDLE;
          cnt_q      <= 6'd0;
          health_q   <= MAX_HEALTH;
          hit_prev_q <= 1'b0;
          stun_q     <= 1'b0;
          invuln_q   <= 1'b0;
        end else begin
          state_q    <= state_d;
          cnt_q      <= cnt_d;
          health_q   <= health_d;
          hit_prev_q <= hitscan_v[gi];
          stun_q     <= stun_d;
          invuln_q   <= invuln_d;
        end
      end
    end
  endgenerate

  assign health1_zero = (g_def[0].health_q == 7'd0);
  assign health2_zero = (g_def[1].health_q == 7'd0);

  always_comb begin
    round_state_d = round_state_q;
    winner_d      = winner_q;
    if (round_start) begin
      round_state_d = ROUND_PLAYING;
      winner_d      = 2'b00;
    end else if (round_state_q == ROUND_PLAYING && (health1_zero || health2_zero)) begin
      round_state_d = ROUND_OVER;
      winner_d      = {health1_zero, health2_zero};
    end
    game_over_d = (round_state_d == ROUND_OVER);
    force_idle  = (round_state_d == ROUND_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_state_q <= ROUND_PLAYING;
      winner_q      <= 2'b00;
      game_over_q   <= 1'b0;
    end else begin
      round_state_q <= round_state_d;
      winner_q      <= winner_d;
      game_over_q   <= game_over_d;
    end
  end

  assign health1   = g_def[0].health_q;
  assign health2   = g_def[1].health_q;
  assign stun1     = g_def[0].stun_q;
  assign stun2     = g_def[1].stun_q;
  assign invuln1   = g_def[0].invuln_q;
  assign invuln2   = g_def[1].invuln_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed self-checking bench for hit_resolver: health, stun/invuln timing,
// trades, saturation, round end and round restart.
module tb_hit_resolver;
  logic       clk = 1'b0;
  logic       rst, frame_tick, round_start, hitscan1, hitscan2;
  logic [3:0] Player1NS, Player2NS;
  logic [6:0] health1, health2;
  logic       stun1, stun2, invuln1, invuln2, game_over;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;

  hit_resolver dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_start(round_start),
    .hitscan1(hitscan1), .hitscan2(hitscan2), .Player1NS(Player1NS), .Player2NS(Player2NS),
    .health1(health1), .health2(health2), .stun1(stun1), .stun2(stun2),
    .invuln1(invuln1), .invuln2(invuln2), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1; frame_tick = 1'b0; round_start = 1'b0;
    hitscan1 = 1'b0; hitscan2 = 1'b0; Player1NS = 4'd0; Player2NS = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic hit1(input logic [3:0] code);
    Player2NS = code; hitscan1 = 1'b1;
    @(negedge clk);
    hitscan1 = 1'b0;
  endtask

  task automatic hit2(input logic [3:0] code);
    Player1NS = code; hitscan2 = 1'b1;
    @(negedge clk);
    hitscan2 = 1'b0;
  endtask

  task automatic trade(input logic [3:0] code);
    Player1NS = code; Player2NS = code; hitscan1 = 1'b1; hitscan2 = 1'b1;
    @(negedge clk);
    hitscan1 = 1'b0; hitscan2 = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (health1 !== 7'd100) begin failures++; $display("FAIL reset_health1 got=%0d exp=100", health1); end
    checks++; if (health2 !== 7'd100) begin failures++; $display("FAIL reset_health2 got=%0d exp=100", health2); end
    checks++; if ({stun1, stun2, invuln1, invuln2} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {stun1, stun2, invuln1, invuln2}); end
    checks++; if ({game_over, winner} !== 3'b000) begin failures++; $display("FAIL reset_round got=%b exp=000", {game_over, winner}); end
    $display("test_reset done");
  endtask

  task automatic test_held_overlap();
    apply_reset();
    Player1NS = 4'd4; hitscan2 = 1'b1;
    @(negedge clk);
    checks++; if (health2 !== 7'd90 || stun2 !== 1'b1) begin failures++; $display("FAIL held_first_hit got h2=%0d stun2=%b exp h2=90 stun2=1", health2, stun2); end
    repeat (49) @(negedge clk);
    checks++; if (health2 !== 7'd90) begin failures++; $display("FAIL held_no_rehit got=%0d exp=90", health2); end
    tick_frames(19);
    checks++; if (stun2 !== 1'b1 || invuln2 !== 1'b0) begin failures++; $display("FAIL held_stun_19 got stun2=%b inv2=%b exp 1 0", stun2, invuln2); end
    tick_frames(1);
    checks++; if (stun2 !== 1'b0 || invuln2 !== 1'b1) begin failures++; $display("FAIL held_stun_end got stun2=%b inv2=%b exp 0 1", stun2, invuln2); end
    tick_frames(29);
    checks++; if (invuln2 !== 1'b1) begin failures++; $display("FAIL held_invuln_29 got=%b exp=1", invuln2); end
    tick_frames(1);
    checks++; if (invuln2 !== 1'b0 || stun2 !== 1'b0) begin failures++; $display("FAIL held_idle got stun2=%b inv2=%b exp 0 0", stun2, invuln2); end
    repeat (3) @(negedge clk);
    checks++; if (health2 !== 7'd90 || health1 !== 7'd100 || stun2 !== 1'b0) begin failures++; $display("FAIL held_after_idle got h1=%0d h2=%0d stun2=%b exp 100 90 0", health1, health2, stun2); end
    hitscan2 = 1'b0;
    $display("test_held_overlap done");
  endtask

  task automatic test_stun_ignores_hit();
    apply_reset();
    hit1(4'd7);
    checks++; if (health1 !== 7'd85 || stun1 !== 1'b1) begin failures++; $display("FAIL dir_hit got h1=%0d stun1=%b exp 85 1", health1, stun1); end
    @(negedge clk);
    hit1(4'd7);
    @(negedge clk);
    checks++; if (health1 !== 7'd85 || stun1 !== 1'b1) begin failures++; $display("FAIL hit_in_stun got h1=%0d stun1=%b exp 85 1", health1, stun1); end
    $display("test_stun_ignores_hit done");
  endtask

  task automatic test_spurious();
    apply_reset();
    hit1(4'd3);
    checks++; if (health1 !== 7'd100 || stun1 !== 1'b0) begin failures++; $display("FAIL spurious got h1=%0d stun1=%b exp 100 0", health1, stun1); end
    @(negedge clk);
    hit1(4'd4);
    checks++; if (health1 !== 7'd90 || stun1 !== 1'b1) begin failures++; $display("FAIL after_spurious got h1=%0d stun1=%b exp 90 1", health1, stun1); end
    $display("test_spurious done");
  endtask

  task automatic test_trade();
    apply_reset();
    trade(4'd4);
    checks++; if (health1 !== 7'd90 || health2 !== 7'd90) begin failures++; $display("FAIL trade_health got h1=%0d h2=%0d exp 90 90", health1, health2); end
    checks++; if (stun1 !== 1'b1 || stun2 !== 1'b1) begin failures++; $display("FAIL trade_stun got %b%b exp 11", stun1, stun2); end
    $display("test_trade done");
  endtask

  task automatic test_tick_with_hit();
    apply_reset();
    Player2NS = 4'd4; hitscan1 = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    hitscan1 = 1'b0; frame_tick = 1'b0;
    checks++; if (health1 !== 7'd90 || stun1 !== 1'b1) begin failures++; $display("FAIL tick_hit got h1=%0d stun1=%b exp 90 1", health1, stun1); end
    tick_frames(19);
    checks++; if (stun1 !== 1'b1) begin failures++; $display("FAIL tick_hit_stun19 got=%b exp=1", stun1); end
    tick_frames(1);
    checks++; if (stun1 !== 1'b0 || invuln1 !== 1'b1) begin failures++; $display("FAIL tick_hit_stun20 got stun1=%b inv1=%b exp 0 1", stun1, invuln1); end
    $display("test_tick_with_hit done");
  endtask

  task automatic test_ko_p2();
    apply_reset();
    for (int i = 0; i < 5; i++) begin hit2(4'd7); tick_frames(50); end
    for (int i = 0; i < 2; i++) begin hit2(4'd4); tick_frames(50); end
    checks++; if (health2 !== 7'd5) begin failures++; $display("FAIL ko_setup got=%0d exp=5", health2); end
    hit2(4'd4);
    checks++; if (health2 !== 7'd0 || game_over !== 1'b0) begin failures++; $display("FAIL ko_saturate got h2=%0d go=%b exp 0 0", health2, game_over); end
    @(negedge clk);
    checks++; if (game_over !== 1'b1 || winner !== 2'b01) begin failures++; $display("FAIL ko_winner got go=%b win=%b exp 1 01", game_over, winner); end
    checks++; if (stun2 !== 1'b0) begin failures++; $display("FAIL ko_stun_cleared got=%b exp=0", stun2); end
    @(negedge clk);
    hit1(4'd7);
    @(negedge clk);
    hit2(4'd7);
    checks++; if (health1 !== 7'd100 || health2 !== 7'd0 || stun1 !== 1'b0) begin failures++; $display("FAIL ko_frozen got h1=%0d h2=%0d stun1=%b exp 100 0 0", health1, health2, stun1); end
    $display("test_ko_p2 done");
  endtask

  task automatic test_draw();
    apply_reset();
    for (int i = 0; i < 6; i++) begin trade(4'd7); tick_frames(50); end
    checks++; if (health1 !== 7'd10 || health2 !== 7'd10) begin failures++; $display("FAIL draw_setup got h1=%0d h2=%0d exp 10 10", health1, health2); end
    trade(4'd4);
    checks++; if (health1 !== 7'd0 || health2 !== 7'd0) begin failures++; $display("FAIL draw_zero got h1=%0d h2=%0d exp 0 0", health1, health2); end
    @(negedge clk);
    checks++; if (game_over !== 1'b1 || winner !== 2'b11) begin failures++; $display("FAIL draw_winner got go=%b win=%b exp 1 11", game_over, winner); end
    $display("test_draw done");
  endtask

  task automatic test_round_start_over();
    round_start = 1'b1;
    @(negedge clk);
    round_start = 1'b0;
    checks++; if (health1 !== 7'd100 || health2 !== 7'd100) begin failures++; $display("FAIL rs_over_health got h1=%0d h2=%0d exp 100 100", health1, health2); end
    checks++; if (game_over !== 1'b0 || winner !== 2'b00) begin failures++; $display("FAIL rs_over_round got go=%b win=%b exp 0 00", game_over, winner); end
    $display("test_round_start_over done");
  endtask

  task automatic test_round_start_stun();
    apply_reset();
    hit1(4'd7);
    @(negedge clk);
    Player1NS = 4'd4; hitscan2 = 1'b1; round_start = 1'b1;
    @(negedge clk);
    hitscan2 = 1'b0; round_start = 1'b0;
    checks++; if (health1 !== 7'd100 || stun1 !== 1'b0) begin failures++; $display("FAIL rs_stun got h1=%0d stun1=%b exp 100 0", health1, stun1); end
    checks++; if (health2 !== 7'd100 || stun2 !== 1'b0) begin failures++; $display("FAIL rs_drops_hit got h2=%0d stun2=%b exp 100 0", health2, stun2); end
    $display("test_round_start_stun done");
  endtask

  task automatic test_rst_mid_stun();
    apply_reset();
    hit2(4'd4);
    checks++; if (health2 !== 7'd90) begin failures++; $display("FAIL rst_mid_pre got=%0d exp=90", health2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (health2 !== 7'd100 || stun2 !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL rst_mid got h2=%0d stun2=%b go=%b exp 100 0 0", health2, stun2, game_over); end
    $display("test_rst_mid_stun done");
  endtask

  initial begin
    test_reset();
    test_held_overlap();
    test_stun_ignores_hit();
    test_spurious();
    test_trade();
    test_tick_with_hit();
    test_ko_p2();
    test_draw();
    test_round_start_over();
    test_round_start_stun();
    test_rst_mid_stun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
